// File: rtl/uart_pkg.sv
// Shared types, frame constants and parity helper for the UART TX/RX engines.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    // Even parity is the XOR of the data bits; odd parity is its inverse.
    function automatic logic calc_parity(input logic [DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: ticks at the end of a bit, or at mid-bit while half is set.
module uart_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    input  logic half,
    output logic tick
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    // Mid-bit tick fires one cycle early to absorb the cycle spent detecting the start edge.
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 2);

    logic [CW-1:0] r_cnt;

    assign tick = (r_cnt == (half ? HALF_LAST : FULL_LAST));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (restart || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_core.sv
// Full-duplex 8-bit UART: independent TX serialiser and RX deserialiser with
// shared parity configuration.
module uart_core
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 send,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    output logic                 tx,
    output logic                 busy,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_error
);

    localparam int unsigned IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    uart_state_t          r_tx_state;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic [IDX_W-1:0]     r_tx_idx;
    logic                 r_tx_pen;
    logic                 r_tx_par;
    logic                 w_tx_restart;
    logic                 w_tx_tick;

    uart_state_t          r_rx_state;
    logic                 r_rx_meta;
    logic                 r_rx_sync;
    logic [DATA_BITS-1:0] r_rx_shift;
    logic [IDX_W-1:0]     r_rx_idx;
    logic                 r_rx_pen;
    logic                 r_rx_podd;
    logic                 r_rx_par;
    logic                 r_rx_wait;
    logic                 w_rx_restart;
    logic                 w_rx_half;
    logic                 w_rx_tick;

    assign w_tx_restart = (r_tx_state == IDLE);
    assign w_rx_restart = (r_rx_state == IDLE);
    assign w_rx_half    = (r_rx_state == START);

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
        .clk     (clk),
        .reset   (reset),
        .restart (w_tx_restart),
        .half    (1'b0),
        .tick    (w_tx_tick)
    );

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
        .clk     (clk),
        .reset   (reset),
        .restart (w_rx_restart),
        .half    (w_rx_half),
        .tick    (w_rx_tick)
    );

    // Transmitter: frame fields are latched at acceptance so input changes mid-frame are ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_state <= IDLE;
            r_tx_shift <= '0;
            r_tx_idx   <= '0;
            r_tx_pen   <= 1'b0;
            r_tx_par   <= 1'b0;
            tx         <= 1'b1;
            busy       <= 1'b0;
        end else begin
            case (r_tx_state)
                IDLE: begin
                    if (send) begin
                        r_tx_shift <= data_in;
                        r_tx_pen   <= parity_en;
                        r_tx_par   <= calc_parity(data_in, parity_odd);
                        tx         <= 1'b0;
                        busy       <= 1'b1;
                        r_tx_state <= START;
                    end
                end
                START: begin
                    if (w_tx_tick) begin
                        tx         <= r_tx_shift[0];
                        r_tx_idx   <= '0;
                        r_tx_state <= DATA;
                    end
                end
                DATA: begin
                    if (w_tx_tick) begin
                        if (r_tx_idx == LAST_IDX) begin
                            if (r_tx_pen) begin
                                tx         <= r_tx_par;
                                r_tx_state <= PARITY;
                            end else begin
                                tx         <= 1'b1;
                                r_tx_state <= STOP;
                            end
                        end else begin
                            tx         <= r_tx_shift[1];
                            r_tx_shift <= {1'b0, r_tx_shift[DATA_BITS-1:1]};
                            r_tx_idx   <= r_tx_idx + IDX_W'(1);
                        end
                    end
                end
                PARITY: begin
                    if (w_tx_tick) begin
                        tx         <= 1'b1;
                        r_tx_state <= STOP;
                    end
                end
                STOP: begin
                    if (w_tx_tick) begin
                        busy       <= 1'b0;
                        r_tx_state <= IDLE;
                    end
                end
                default: r_tx_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    // Receiver: IDLE is only entered with the line high, so a low level there is a falling edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_state   <= IDLE;
            r_rx_shift   <= '0;
            r_rx_idx     <= '0;
            r_rx_pen     <= 1'b0;
            r_rx_podd    <= 1'b0;
            r_rx_par     <= 1'b0;
            r_rx_wait    <= 1'b0;
            data_out     <= '0;
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            case (r_rx_state)
                IDLE: begin
                    if (!r_rx_sync) begin
                        r_rx_state <= START;
                    end
                end
                START: begin
                    if (w_rx_tick) begin
                        if (!r_rx_sync) begin
                            r_rx_pen   <= parity_en;
                            r_rx_podd  <= parity_odd;
                            r_rx_idx   <= '0;
                            r_rx_state <= DATA;
                        end else begin
                            r_rx_state <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (w_rx_tick) begin
                        r_rx_shift <= {r_rx_sync, r_rx_shift[DATA_BITS-1:1]};
                        if (r_rx_idx == LAST_IDX) begin
                            r_rx_state <= r_rx_pen ? PARITY : STOP;
                        end else begin
                            r_rx_idx <= r_rx_idx + IDX_W'(1);
                        end
                    end
                end
                PARITY: begin
                    if (w_rx_tick) begin
                        r_rx_par   <= r_rx_sync;
                        r_rx_state <= STOP;
                    end
                end
                STOP: begin
                    if (r_rx_wait) begin
                        if (r_rx_sync) begin
                            r_rx_wait  <= 1'b0;
                            r_rx_state <= IDLE;
                        end
                    end else if (w_rx_tick) begin
                        if (r_rx_sync) begin
                            data_out     <= r_rx_shift;
                            parity_error <= r_rx_pen & (r_rx_par != calc_parity(r_rx_shift, r_rx_podd));
                            data_valid   <= 1'b1;
                            r_rx_state   <= IDLE;
                        end else begin
                            r_rx_wait <= 1'b1;
                        end
                    end
                end
                default: r_rx_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_core.sv
// Directed self-checking bench for uart_core: TX framing, loopback, parity,
// busy/reset behaviour, glitch rejection and framing errors.
module tb_uart_core;

    localparam int unsigned CPB = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       send;
    logic       parity_en;
    logic       parity_odd;
    logic       tx;
    logic       busy;
    logic       w_rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_error;

    logic       loop_en;
    logic       rx_drv;

    int checks   = 0;
    int errors   = 0;
    int dv_count = 0;

    assign w_rx = loop_en ? tx : rx_drv;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (data_valid === 1'b1) dv_count++;
    end

    uart_core #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .send         (send),
        .parity_en    (parity_en),
        .parity_odd   (parity_odd),
        .tx           (tx),
        .busy         (busy),
        .rx           (w_rx),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .parity_error (parity_error)
    );

    // Pulses send for one accepting edge; returns 1ns after that edge.
    task automatic start_tx(input logic [7:0] d, input logic pen, input logic podd);
        @(posedge clk); #1;
        data_in    = d;
        parity_en  = pen;
        parity_odd = podd;
        send       = 1'b1;
        @(posedge clk); #1;
        send = 1'b0;
    endtask

    task automatic bit_time();
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic drive_rx_frame(input logic [7:0] d, input logic pen, input logic pbit, input logic sbit);
        @(posedge clk); #1;
        rx_drv = 1'b0;
        bit_time();
        for (int k = 0; k < 8; k++) begin
            rx_drv = d[k];
            bit_time();
        end
        if (pen) begin
            rx_drv = pbit;
            bit_time();
        end
        rx_drv = sbit;
        bit_time();
        rx_drv = 1'b1;
        bit_time();
    endtask

    task automatic test_reset();
        reset = 1'b0; send = 1'b0; data_in = '0; parity_en = 1'b0; parity_odd = 1'b0;
        loop_en = 1'b0; rx_drv = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_dv: got %b want 0", data_valid); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %h want 00", data_out); end
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_tx_frame();
        logic [9:0] frame;
        frame = {1'b1, 8'hA5, 1'b0};
        start_tx(8'hA5, 1'b0, 1'b0);
        for (int i = 0; i < 160; i++) begin
            @(negedge clk);
            if (i % 16 == 8) begin
                checks++;
                if (tx !== frame[i/16]) begin errors++; $display("FAIL tx_bit%0d: got %b want %b", i/16, tx, frame[i/16]); end
            end
            checks++;
            if (busy !== 1'b1) begin errors++; $display("FAIL tx_busy_cycle%0d: got %b want 1", i, busy); end
        end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tx_busy_fall: got %b want 0", busy); end
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL tx_idle_after: got %b want 1", tx); end
    endtask

    task automatic loopback_frame(input logic [7:0] d, input logic pen, input logic podd, input logic exp_par);
        int base;
        int hit_at;
        int exp_at;
        base   = dv_count;
        hit_at = -1;
        exp_at = pen ? 170 : 154;
        loop_en = 1'b1;
        start_tx(d, pen, podd);
        for (int i = 0; i < 220; i++) begin
            @(negedge clk);
            if (pen && i == 152) begin
                checks++;
                if (tx !== exp_par) begin errors++; $display("FAIL lb_parity_bit_%h: got %b want %b", d, tx, exp_par); end
            end
            if (data_valid === 1'b1 && hit_at < 0) hit_at = i;
        end
        checks++; if (hit_at != exp_at) begin errors++; $display("FAIL lb_latency_%h: got %0d want %0d", d, hit_at, exp_at); end
        checks++; if (dv_count - base != 1) begin errors++; $display("FAIL lb_pulses_%h: got %0d want 1", d, dv_count - base); end
        checks++; if (data_out !== d) begin errors++; $display("FAIL lb_data_%h: got %h want %h", d, data_out, d); end
        checks++; if (parity_error !== 1'b0) begin errors++; $display("FAIL lb_perr_%h: got %b want 0", d, parity_error); end
        loop_en = 1'b0;
    endtask

    task automatic test_loopback_plain();
        loopback_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_loopback_parity();
        loopback_frame(8'h07, 1'b1, 1'b0, 1'b1);
        loopback_frame(8'h00, 1'b1, 1'b1, 1'b1);
        parity_en = 1'b0; parity_odd = 1'b0;
    endtask

    task automatic test_parity_error();
        int base;
        parity_en = 1'b1; parity_odd = 1'b0;
        base = dv_count;
        drive_rx_frame(8'h55, 1'b1, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        checks++; if (dv_count - base != 1) begin errors++; $display("FAIL perr_pulses: got %0d want 1", dv_count - base); end
        checks++; if (parity_error !== 1'b1) begin errors++; $display("FAIL perr_flag: got %b want 1", parity_error); end
        checks++; if (data_out !== 8'h55) begin errors++; $display("FAIL perr_data: got %h want 55", data_out); end
        parity_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        data_in = 8'hC3; parity_en = 1'b0; send = 1'b1;
        @(posedge clk); #1;
        repeat (161) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_gap_busy: got %b want 0", busy); end
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL b2b_gap_tx: got %b want 1", tx); end
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_restart_busy: got %b want 1", busy); end
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL b2b_restart_tx: got %b want 0", tx); end
        send = 1'b0;
        repeat (170) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_end_busy: got %b want 0", busy); end
    endtask

    task automatic test_busy_reset();
        int base;
        int busy_seen;
        base = dv_count;
        busy_seen = 0;
        loop_en = 1'b1;
        start_tx(8'h81, 1'b0, 1'b0);
        for (int i = 0; i < 160; i++) begin
            @(negedge clk);
            if (i == 40) begin data_in = 8'hFF; parity_en = 1'b1; send = 1'b1; end
            if (i == 42) begin send = 1'b0; parity_en = 1'b0; end
            if (i == 41) begin
                checks++;
                if (busy !== 1'b1) begin errors++; $display("FAIL busy_held: got %b want 1", busy); end
            end
        end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_single_end: got %b want 0", busy); end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy !== 1'b0) busy_seen++;
        end
        checks++; if (busy_seen != 0) begin errors++; $display("FAIL busy_no_second: got %0d busy cycles want 0", busy_seen); end
        checks++; if (dv_count - base != 1) begin errors++; $display("FAIL busy_rx_pulses: got %0d want 1", dv_count - base); end
        checks++; if (data_out !== 8'h81) begin errors++; $display("FAIL busy_rx_data: got %h want 81", data_out); end

        base = dv_count;
        start_tx(8'hF0, 1'b0, 1'b0);
        repeat (50) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL midreset_tx: got %b want 1", tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", busy); end
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (200) @(negedge clk);
        checks++; if (dv_count - base != 0) begin errors++; $display("FAIL midreset_dv: got %0d want 0", dv_count - base); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL midreset_data: got %h want 00", data_out); end
        loop_en = 1'b0;
    endtask

    task automatic test_glitch_framing();
        int base;
        base = dv_count;
        @(posedge clk); #1;
        rx_drv = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rx_drv = 1'b1;
        repeat (40) @(negedge clk);
        checks++; if (dv_count - base != 0) begin errors++; $display("FAIL glitch_dv: got %0d want 0", dv_count - base); end

        base = dv_count;
        drive_rx_frame(8'h12, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        checks++; if (dv_count - base != 1) begin errors++; $display("FAIL good_pulses: got %0d want 1", dv_count - base); end
        checks++; if (data_out !== 8'h12) begin errors++; $display("FAIL good_data: got %h want 12", data_out); end

        base = dv_count;
        drive_rx_frame(8'hEE, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        checks++; if (dv_count - base != 0) begin errors++; $display("FAIL framing_dv: got %0d want 0", dv_count - base); end
        checks++; if (data_out !== 8'h12) begin errors++; $display("FAIL framing_data: got %h want 12", data_out); end
        checks++; if (parity_error !== 1'b0) begin errors++; $display("FAIL framing_perr: got %b want 0", parity_error); end

        base = dv_count;
        drive_rx_frame(8'h34, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        checks++; if (dv_count - base != 1) begin errors++; $display("FAIL recover_pulses: got %0d want 1", dv_count - base); end
        checks++; if (data_out !== 8'h34) begin errors++; $display("FAIL recover_data: got %h want 34", data_out); end
    endtask

    initial begin
        test_reset();
        test_tx_frame();
        test_loopback_plain();
        test_loopback_parity();
        test_parity_error();
        test_back_to_back();
        test_busy_reset();
        test_glitch_framing();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
